// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard sequencer: FSM states, register-index width and the
// zero-register constant.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned PIPE_REG_W = 5;

    localparam logic [PIPE_REG_W-1:0] ZERO_REG = '0;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } state_e;

    // Width of the timeout counter; kept at least 1 bit so MEM_TMO=0 still elaborates.
    function automatic int unsigned tmo_width(input int unsigned tmo);
        return (tmo == 0) ? 1 : $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipe_hazard_ctrl_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != CntMax)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes, memory waits
// with timeout, plus saturating stall/flush counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W   = PIPE_REG_W,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MEM_TMO = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             idex_memrd_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             br_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             err_o
);

    localparam int unsigned TmoW = tmo_width(MEM_TMO);
    localparam logic [TmoW-1:0] TmoLast = TmoW'((MEM_TMO == 0) ? 0 : MEM_TMO - 1);

    state_e          r_state, w_state_d;
    logic [TmoW-1:0] r_tmo, w_tmo_d;
    logic            r_err, w_err_d;

    logic w_load_use;
    logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_bubble, w_freeze;

    assign w_load_use = idex_memrd_i && (idex_rt_i != REG_W'(ZERO_REG)) &&
                        ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

    always_comb begin
        w_state_d     = r_state;
        w_tmo_d       = r_tmo;
        w_err_d       = r_err;
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_freeze      = 1'b0;

        unique case (r_state)
            StRun: begin
                if (mem_req_i && !mem_ack_i) begin
                    w_freeze     = 1'b1;
                    w_pc_write   = 1'b0;
                    w_ifid_write = 1'b0;
                    w_state_d    = StMemWait;
                    w_tmo_d      = '0;
                end else if (w_load_use) begin
                    // A taken branch is dropped here; it is re-resolved once the stall clears.
                    w_pc_write    = 1'b0;
                    w_ifid_write  = 1'b0;
                    w_idex_bubble = 1'b1;
                end else if (br_taken_i) begin
                    w_ifid_flush = 1'b1;
                    w_ifid_write = 1'b0;
                end
            end
            StMemWait: begin
                w_freeze     = 1'b1;
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
                if (mem_ack_i) begin
                    w_state_d = StRun;
                    w_tmo_d   = '0;
                end else if ((MEM_TMO != 0) && (r_tmo == TmoLast)) begin
                    w_state_d = StErr;
                    w_err_d   = 1'b1;
                end else begin
                    w_tmo_d = r_tmo + TmoW'(1);
                end
            end
            StErr: begin
                w_freeze     = 1'b1;
                w_pc_write   = 1'b0;
                w_ifid_write = 1'b0;
            end
            default: begin
                w_state_d = StRun;
            end
        endcase

        if (rst_i) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
            w_freeze      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StRun;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_tmo   <= w_tmo_d;
            r_err   <= w_err_d;
        end
    end

    pipe_hazard_ctrl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk (clk_i),
        .i_clr (rst_i),
        .i_inc (!w_pc_write),
        .o_cnt (stall_cnt_o)
    );

    pipe_hazard_ctrl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .i_clk (clk_i),
        .i_clr (rst_i),
        .i_inc (w_ifid_flush),
        .o_cnt (flush_cnt_o)
    );

    assign pc_write_o    = w_pc_write;
    assign ifid_write_o  = w_ifid_write;
    assign ifid_flush_o  = w_ifid_flush;
    assign idex_bubble_o = w_idex_bubble;
    assign freeze_o      = w_freeze;
    assign err_o         = r_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: a default-parameter instance and a small one (CNT_W=4, MEM_TMO=8) share stimulus.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       memrd;
    logic [4:0] ex_rt;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       br;
    logic       req;
    logic       ack;

    logic        a_pc, a_ifw, a_fl, a_bub, a_frz, a_err;
    logic [15:0] a_stall, a_flush;
    logic        b_pc, b_ifw, b_fl, b_bub, b_frz, b_err;
    logic [3:0]  b_stall, b_flush;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut_a (
        .clk_i         (clk),
        .rst_i         (rst),
        .idex_memrd_i  (memrd),
        .idex_rt_i     (ex_rt),
        .ifid_rs_i     (id_rs),
        .ifid_rt_i     (id_rt),
        .br_taken_i    (br),
        .mem_req_i     (req),
        .mem_ack_i     (ack),
        .pc_write_o    (a_pc),
        .ifid_write_o  (a_ifw),
        .ifid_flush_o  (a_fl),
        .idex_bubble_o (a_bub),
        .freeze_o      (a_frz),
        .stall_cnt_o   (a_stall),
        .flush_cnt_o   (a_flush),
        .err_o         (a_err)
    );

    pipe_hazard_ctrl #(
        .CNT_W   (4),
        .MEM_TMO (8)
    ) u_dut_b (
        .clk_i         (clk),
        .rst_i         (rst),
        .idex_memrd_i  (memrd),
        .idex_rt_i     (ex_rt),
        .ifid_rs_i     (id_rs),
        .ifid_rt_i     (id_rt),
        .br_taken_i    (br),
        .mem_req_i     (req),
        .mem_ack_i     (ack),
        .pc_write_o    (b_pc),
        .ifid_write_o  (b_ifw),
        .ifid_flush_o  (b_fl),
        .idex_bubble_o (b_bub),
        .freeze_o      (b_frz),
        .stall_cnt_o   (b_stall),
        .flush_cnt_o   (b_flush),
        .err_o         (b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, freeze}
    task automatic chk_ctl(input string tag, input logic [4:0] exp_a, input logic [4:0] exp_b);
        chk({tag, "_a"}, {27'd0, a_pc, a_ifw, a_fl, a_bub, a_frz}, {27'd0, exp_a});
        chk({tag, "_b"}, {27'd0, b_pc, b_ifw, b_fl, b_bub, b_frz}, {27'd0, exp_b});
    endtask

    task automatic chk_cnt(input string tag, input int sa, input int fa, input int sb, input int fb);
        chk({tag, "_stall_a"}, 32'(a_stall), sa);
        chk({tag, "_flush_a"}, 32'(a_flush), fa);
        chk({tag, "_stall_b"}, 32'(b_stall), sb);
        chk({tag, "_flush_b"}, 32'(b_flush), fb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memrd = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0;
        br = 1'b0; req = 1'b0; ack = 1'b0;
    endtask

    localparam logic [4:0] CtlRst    = 5'b00110;
    localparam logic [4:0] CtlRun    = 5'b11000;
    localparam logic [4:0] CtlStall  = 5'b00010;
    localparam logic [4:0] CtlFlush  = 5'b10100;
    localparam logic [4:0] CtlFreeze = 5'b00001;

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk_ctl("rst_ctl", CtlRst, CtlRst);
        tick();
        tick();
        chk_cnt("rst_cnt", 0, 0, 0, 0);
        chk("rst_err_a", 32'(a_err), 0);
        chk("rst_err_b", 32'(b_err), 0);

        rst = 1'b0;
        #1;
        chk_ctl("idle", CtlRun, CtlRun);
        tick();

        // Load-use via rs
        memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd3;
        #1;
        chk_ctl("lu_rs", CtlStall, CtlStall);
        tick();
        idle();
        #1;
        chk_ctl("lu_rs_after", CtlRun, CtlRun);
        chk_cnt("lu_rs", 1, 0, 1, 0);

        // Register 0 never hazards
        memrd = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        chk_ctl("lu_r0", CtlRun, CtlRun);
        tick();

        // Load-use via rt
        memrd = 1'b1; ex_rt = 5'd7; id_rs = 5'd2; id_rt = 5'd7;
        #1;
        chk_ctl("lu_rt", CtlStall, CtlStall);
        tick();
        idle();
        #1;
        chk_cnt("lu_rt", 2, 0, 2, 0);

        // Taken branch
        br = 1'b1;
        #1;
        chk_ctl("br", CtlFlush, CtlFlush);
        tick();
        #1;
        chk_cnt("br", 2, 1, 2, 1);

        // Load-use outranks branch
        memrd = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
        #1;
        chk_ctl("br_lu", CtlStall, CtlStall);
        tick();
        idle();
        #1;
        chk_cnt("br_lu", 3, 1, 3, 1);

        // Memory wait, ack on 4th wait cycle; hazards during the wait are ignored
        req = 1'b1;
        #1;
        chk_ctl("mw_req", CtlFreeze, CtlFreeze);
        tick();
        req = 1'b0; br = 1'b1; memrd = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ack = 1'b1;
            #1;
            chk_ctl($sformatf("mw_wait%0d", i), CtlFreeze, CtlFreeze);
            tick();
        end
        idle();
        #1;
        chk_ctl("mw_done", CtlRun, CtlRun);
        chk_cnt("mw_done", 8, 1, 8, 1);

        // Request acknowledged in the same cycle: no stall
        req = 1'b1; ack = 1'b1;
        #1;
        chk_ctl("mw_same", CtlRun, CtlRun);
        tick();
        idle();
        #1;
        chk_cnt("mw_same", 8, 1, 8, 1);

        // Timeout: B errors after 8 wait cycles, A (MEM_TMO=64) keeps waiting
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_pre_err_b", 32'(b_err), 0);
        tick();
        chk("tmo_err_b", 32'(b_err), 1);
        chk("tmo_err_a", 32'(a_err), 0);
        chk_cnt("tmo", 17, 1, 15, 1);
        ack = 1'b1;
        #1;
        chk_ctl("tmo_ack", CtlFreeze, CtlFreeze);
        tick();
        #1;
        chk_ctl("tmo_late_ack", CtlRun, CtlFreeze);
        chk("tmo_sticky_b", 32'(b_err), 1);
        chk("tmo_stall_a", 32'(a_stall), 18);

        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        #1;
        chk_ctl("tmo_rst", CtlRun, CtlRun);
        chk("tmo_rst_err_b", 32'(b_err), 0);
        chk_cnt("tmo_rst", 0, 0, 0, 0);

        // Saturation: hold load-use 20 cycles
        memrd = 1'b1; ex_rt = 5'd12; id_rs = 5'd12;
        for (int i = 0; i < 15; i++) tick();
        chk_cnt("sat15", 15, 0, 15, 0);
        for (int i = 0; i < 5; i++) tick();
        chk_cnt("sat20", 20, 0, 15, 0);
        idle();

        // Reset in the middle of a memory wait
        req = 1'b1;
        tick();
        req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk_ctl("mw_rst_ctl", CtlRst, CtlRst);
        tick();
        rst = 1'b0;
        #1;
        chk_ctl("mw_rst_run", CtlRun, CtlRun);
        chk_cnt("mw_rst", 0, 0, 0, 0);
        chk("mw_rst_err_b", 32'(b_err), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
